// File: rtl/start_controller.sv
// Kernel start controller: latches a kernel ID, drives start while the
// kernel runs, counts output tokens and waits for input drain before done.
module start_controller #(
    parameter int SIZEID  = 8,
    parameter int NCH     = 2,
    parameter int SIZECNT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               id_wr,
    input  logic [SIZEID-1:0]  kernelID,
    input  logic [SIZECNT-1:0] length,
    input  logic               abort,
    input  logic               out_tok,
    input  logic [NCH-1:0]     ch_empty,
    output logic [SIZEID-1:0]  active_id,
    output logic               start,
    output logic               busy,
    output logic               done,
    output logic               id_err,
    output logic [SIZECNT-1:0] tok_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [SIZECNT-1:0] ONE = SIZECNT'(1);

    state_t             state, state_n;
    logic [SIZEID-1:0]  id_n;
    logic [SIZECNT-1:0] len_r, len_n;
    logic [SIZECNT-1:0] cnt_n;
    logic               err_n;
    logic               last_tok;

    assign last_tok = out_tok && (len_r != '0) && (tok_count == len_r - ONE);

    always_comb begin
        state_n = state;
        id_n    = active_id;
        len_n   = len_r;
        cnt_n   = tok_count;
        err_n   = id_wr && ((state != IDLE) || (kernelID == '0));
        case (state)
            IDLE: begin
                if (id_wr && (kernelID != '0)) begin
                    state_n = LOAD;
                    id_n    = kernelID;
                    len_n   = length;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                state_n = abort ? DRAIN : RUN;
            end
            RUN: begin
                if (out_tok)
                    cnt_n = tok_count + ONE;
                if (abort || last_tok)
                    state_n = DRAIN;
            end
            DRAIN: begin
                // late tokens still counted, but never wrap past all-ones
                if (out_tok && (tok_count != '1))
                    cnt_n = tok_count + ONE;
                if (&ch_empty)
                    state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
                id_n    = '0;
            end
            default: begin
                state_n = IDLE;
                id_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            active_id <= '0;
            len_r     <= '0;
            tok_count <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            id_err    <= 1'b0;
        end else begin
            state     <= state_n;
            active_id <= id_n;
            len_r     <= len_n;
            tok_count <= cnt_n;
            start     <= (state_n == RUN);
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE);
            id_err    <= err_n;
        end
    end

endmodule

// File: tb/tb_start_controller.sv
// Directed bench for start_controller: bounded, unbounded, drain-stall,
// rejected writes and mid-run reset.
module tb_start_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_wr;
    logic [7:0]  kernelID;
    logic [15:0] length;
    logic        abort;
    logic        out_tok;
    logic [1:0]  ch_empty;
    logic [7:0]  active_id;
    logic        start;
    logic        busy;
    logic        done;
    logic        id_err;
    logic [15:0] tok_count;

    int checks = 0;
    int errors = 0;

    start_controller #(.SIZEID(8), .NCH(2), .SIZECNT(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .id_wr     (id_wr),
        .kernelID  (kernelID),
        .length    (length),
        .abort     (abort),
        .out_tok   (out_tok),
        .ch_empty  (ch_empty),
        .active_id (active_id),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .id_err    (id_err),
        .tok_count (tok_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [7:0] k, input logic [15:0] l);
        id_wr    = 1'b1;
        kernelID = k;
        length   = l;
        tick();
        id_wr    = 1'b0;
        kernelID = '0;
        length   = '0;
    endtask

    initial begin
        reset    = 1'b1;
        id_wr    = 1'b0;
        kernelID = '0;
        length   = '0;
        abort    = 1'b0;
        out_tok  = 1'b0;
        ch_empty = 2'b11;
        tick();
        tick();
        chk("rst_id", 32'(active_id), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(id_err), 0);
        chk("rst_cnt", 32'(tok_count), 0);
        reset = 1'b0;
        tick();

        // 1: bounded run of 3 tokens
        write(8'd5, 16'd3);
        chk("t1_load_id", 32'(active_id), 5);
        chk("t1_load_start", 32'(start), 0);
        chk("t1_load_busy", 32'(busy), 1);
        tick();
        chk("t1_run_start", 32'(start), 1);
        out_tok = 1'b1;
        tick();
        tick();
        chk("t1_cnt2", 32'(tok_count), 2);
        chk("t1_start2", 32'(start), 1);
        tick();
        out_tok = 1'b0;
        chk("t1_cnt3", 32'(tok_count), 3);
        chk("t1_stop", 32'(start), 0);
        chk("t1_drain_done", 32'(done), 0);
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_done_busy", 32'(busy), 1);
        tick();
        chk("t1_done_off", 32'(done), 0);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_id", 32'(active_id), 0);
        chk("t1_hold_cnt", 32'(tok_count), 3);

        // 2: kernel 0 rejected
        write(8'd0, 16'd4);
        chk("t2_err", 32'(id_err), 1);
        chk("t2_busy", 32'(busy), 0);
        chk("t2_start", 32'(start), 0);
        chk("t2_cnt", 32'(tok_count), 3);
        tick();
        chk("t2_err_off", 32'(id_err), 0);
        chk("t2_start2", 32'(start), 0);

        // 3: unbounded run, 20 tokens then abort
        write(8'd2, 16'd0);
        chk("t3_cnt_clr", 32'(tok_count), 0);
        tick();
        out_tok = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        out_tok = 1'b0;
        chk("t3_cnt20", 32'(tok_count), 20);
        chk("t3_running", 32'(start), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_stop", 32'(start), 0);
        chk("t3_abort_cnt", 32'(tok_count), 20);
        tick();
        chk("t3_done", 32'(done), 1);
        tick();
        chk("t3_idle", 32'(busy), 0);

        // 4: drain stall until all channels empty
        ch_empty = 2'b01;
        write(8'd9, 16'd4);
        tick();
        out_tok = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_tok = 1'b0;
        chk("t4_cnt4", 32'(tok_count), 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_start", 32'(start), 0);
            chk("t4_hold_done", 32'(done), 0);
            chk("t4_hold_busy", 32'(busy), 1);
        end
        ch_empty = 2'b11;
        tick();
        chk("t4_done", 32'(done), 1);
        tick();
        chk("t4_done_off", 32'(done), 0);
        chk("t4_idle", 32'(busy), 0);

        // 5: write during run is rejected
        write(8'd3, 16'd2);
        tick();
        write(8'd7, 16'd9);
        chk("t5_err", 32'(id_err), 1);
        chk("t5_id", 32'(active_id), 3);
        chk("t5_start", 32'(start), 1);
        tick();
        chk("t5_err_off", 32'(id_err), 0);
        out_tok = 1'b1;
        tick();
        tick();
        out_tok = 1'b0;
        chk("t5_cnt", 32'(tok_count), 2);
        chk("t5_stop", 32'(start), 0);
        tick();
        chk("t5_done", 32'(done), 1);
        tick();
        chk("t5_idle_id", 32'(active_id), 0);

        // 6: reset mid-run, then a clean restart
        write(8'd6, 16'd10);
        tick();
        out_tok = 1'b1;
        tick();
        tick();
        out_tok = 1'b0;
        chk("t6_cnt2", 32'(tok_count), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_id", 32'(active_id), 0);
        chk("t6_rst_start", 32'(start), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_cnt", 32'(tok_count), 0);
        write(8'd1, 16'd1);
        chk("t6_new_id", 32'(active_id), 1);
        tick();
        chk("t6_new_start", 32'(start), 1);
        out_tok = 1'b1;
        tick();
        out_tok = 1'b0;
        chk("t6_new_cnt", 32'(tok_count), 1);
        chk("t6_new_stop", 32'(start), 0);
        tick();
        chk("t6_new_done", 32'(done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/start_controller.md
Name: start_controller

Overview:
Sequential successor to the combinational kernel-start decoder in the Multi-Dataflow Composer platform layer. Latches a kernel ID on a configuration write and holds it stable on the switch-box ID bus for the whole run. Drives a registered start level while the kernel runs, counts output tokens against a programmed length, and waits for all input channels to drain before signalling completion. Sits between the host/coprocessor register interface and the multi-dataflow network.

Parameters:
SIZEID, 8, width of kernel ID
NCH, 2, number of network input channels monitored for drain
SIZECNT, 16, width of token length and token counter

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
id_wr  input  1  one-cycle write strobe for kernelID/length
kernelID  input  SIZEID  requested kernel ID; 0 means no kernel
length  input  SIZECNT  output tokens to process; 0 means unbounded run
abort  input  1  request early stop of current run
out_tok  input  1  one output token accepted by the consumer this cycle
ch_empty  input  NCH  per-channel input FIFO empty flags
active_id  output  SIZEID  kernel ID driven to the network, stable for the whole run
start  output  1  network start/enable level
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
id_err  output  1  one-cycle pulse: write rejected
tok_count  output  SIZECNT  output tokens counted in current or last run

Behaviour:
- All outputs registered. Reset values: active_id=0, start=0, busy=0, done=0, id_err=0, tok_count=0, state=IDLE. Reset has priority over every other input in every state.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE, id_wr=1, kernelID!=0: latch kernelID into active_id and length into len_r, clear tok_count, go to LOAD.
- IDLE, id_wr=1, kernelID==0: stay in IDLE, pulse id_err next cycle, registers unchanged.
- LOAD: one cycle, start=0, active_id valid so the switch-box configuration settles. Next state is RUN, or DRAIN if abort=1.
- RUN: start=1.
  - Each cycle with out_tok=1: tok_count increments by 1.
  - Bounded run (len_r!=0): when out_tok=1 and tok_count==len_r-1, the token is counted and the state moves to DRAIN.
  - Unbounded run (len_r==0): tok_count wraps modulo 2^SIZECNT. Only abort ends the run.
  - abort=1: go to DRAIN. If abort and the final token coincide, the token is still counted and the next state is DRAIN.
- DRAIN: start=0. out_tok is still counted; tok_count saturates at all-ones in this state, no wrap. When &ch_empty==1, go to DONE. abort is ignored.
- DONE: done=1 for exactly this cycle, then IDLE. active_id returns to 0 on entry to IDLE. tok_count holds its value until the next accepted write.
- id_wr in any state other than IDLE: ignored, id_err pulses one cycle later, and the run is unaffected.
- busy=1 in LOAD, RUN, DRAIN and DONE.
- Timing: id_wr accepted at edge t gives LOAD during t+1 and start=1 from t+2. The final token at edge u gives start=0 from u+1. ch_empty all-high sampled at edge v gives done=1 during v+1.
- start is 0 for any kernelID==0, which keeps the original decoder semantics.

Test Plan:
1. Reset, then id_wr with kernelID=5, length=3; out_tok on 3 cycles; ch_empty=2'b11 -> active_id=5 from t+1, start high from t+2 until after the 3rd token, tok_count=3, one done pulse, active_id=0 afterwards.
2. id_wr with kernelID=0 -> start stays 0, busy stays 0, id_err=1 for one cycle.
3. id_wr with kernelID=2, length=0; 20 out_tok; abort -> start falls on the cycle after abort, tok_count=20, done after drain.
4. Bounded run with length=4, ch_empty=2'b01 held for 5 cycles after the 4th token, then 2'b11 -> state held in DRAIN with start=0 and done=0, then one done pulse.
5. id_wr with kernelID=7 during RUN of kernelID=3 -> id_err pulses, active_id stays 3, run completes normally.
6. reset asserted mid-RUN with tok_count=2 -> next cycle all outputs at reset values; a new id_wr starts cleanly.
